// File: rtl/msg_ram_pkg.sv
// Shared definitions for the message RAM arbiter: ownership state encoding,
// default RAM geometry and owner constants.
package msg_ram_pkg;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ERRCNT_W = 8;

  typedef enum logic [1:0] {
    ST_HOST_OWN = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_GEN_OWN  = 2'd2,
    ST_RELEASE  = 2'd3
  } arb_state_e;

  localparam logic OWNER_HOST = 1'b0;
  localparam logic OWNER_GEN  = 1'b1;
endpackage

// File: rtl/msg_ram_arbiter_if.sv
// Host, modulator and RAM-side signals of the message RAM arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface msg_ram_arbiter_if
  import msg_ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_err;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              gen_req;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_gnt;
  logic              gen_rvalid;
  logic [DATA_W-1:0] gen_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, gen_req, gen_addr, ram_rdata,
    output host_gnt, host_err, host_rvalid, host_rdata,
           gen_gnt, gen_rvalid, gen_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output host_req, host_we, host_addr, host_wdata, gen_req, gen_addr, ram_rdata,
    input  host_gnt, host_err, host_rvalid, host_rdata,
           gen_gnt, gen_rvalid, gen_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/msg_ram_arbiter_sat_counter.sv
// Saturating up-counter, increment 0..2 per cycle, synchronous clear wins.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic [1:0]   inc,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q, cnt_d;
  logic [W:0]   sum;

  always_comb begin
    sum = {1'b0, cnt_q} + {{(W-1){1'b0}}, inc};
    if (clr)         cnt_d = '0;
    else if (sum[W]) cnt_d = '1;
    else             cnt_d = sum[W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/msg_ram_arbiter.sv
// Owns the single port of the message RAM, sharing it between the SPI host and
// the modulator through an ownership FSM with grant/err/rvalid handshakes.
module msg_ram_arbiter
  import msg_ram_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ERRCNT_W = DEF_ERRCNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tx_active,
  input  logic                err_clr,
  output logic                gen_owner,
  output logic [ERRCNT_W-1:0] err_count,
  msg_ram_arbiter_if.slave    bus
);
  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              host_rv_q, host_rv_d;
  logic              gen_rv_q, gen_rv_d;
  logic              host_ok, gen_ok, host_rej, gen_rej;
  logic [1:0]        rej_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_HOST_OWN;
    else       state_q <= state_d;
  end

  // DRAIN and RELEASE each last exactly one cycle so any in-flight read lands
  // before the other side can touch the port.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HOST_OWN: if (tx_active) state_d = ST_DRAIN;
      ST_DRAIN:    state_d = tx_active ? ST_GEN_OWN : ST_RELEASE;
      ST_GEN_OWN:  if (!tx_active) state_d = ST_RELEASE;
      ST_RELEASE:  state_d = ST_HOST_OWN;
      default:     state_d = ST_HOST_OWN;
    endcase
  end

  always_comb begin
    host_ok   = bus.host_req && (state_q == ST_HOST_OWN);
    gen_ok    = bus.gen_req  && (state_q == ST_GEN_OWN);
    host_rej  = bus.host_req && !host_ok;
    gen_rej   = bus.gen_req  && !gen_ok;
    rej_cnt   = {1'b0, host_rej} + {1'b0, gen_rej};
    host_rv_d = host_ok && !bus.host_we;
    gen_rv_d  = gen_ok;
    gen_owner = (state_q == ST_GEN_OWN) ? OWNER_GEN : OWNER_HOST;

    // RAM bus holds the last granted values while idle to avoid toggling.
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (host_ok) begin
      addr_d = bus.host_addr;
      if (bus.host_we) wdata_d = bus.host_wdata;
    end else if (gen_ok) begin
      addr_d = bus.gen_addr;
    end

    bus.ram_addr    = addr_d;
    bus.ram_wdata   = wdata_d;
    bus.ram_we      = host_ok && bus.host_we;
    bus.host_gnt    = host_ok;
    bus.host_err    = host_rej;
    bus.gen_gnt     = gen_ok;
    bus.host_rvalid = host_rv_q;
    bus.host_rdata  = host_rv_q ? bus.ram_rdata : '0;
    bus.gen_rvalid  = gen_rv_q;
    bus.gen_rdata   = gen_rv_q ? bus.ram_rdata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      host_rv_q <= 1'b0;
      gen_rv_q  <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      host_rv_q <= host_rv_d;
      gen_rv_q  <= gen_rv_d;
    end
  end

  sat_counter #(.W(ERRCNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (err_clr),
    .inc   (rej_cnt),
    .count (err_count)
  );
endmodule

// File: tb/tb_msg_ram_arbiter.sv
// Randomized + directed bench for msg_ram_arbiter against an ownership-level
// reference model and a behavioural 1024x8 registered-output RAM.
module tb_msg_ram_arbiter;
  import msg_ram_pkg::*;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          reset, tx_active, err_clr, gen_owner;
  logic [EW-1:0] err_count;

  msg_ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  msg_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ERRCNT_W(EW)) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_active (tx_active),
    .err_clr   (err_clr),
    .gen_owner (gen_owner),
    .err_count (err_count),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  // Physical RAM: written only by what the DUT actually drives.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  // Reference model: who owns the RAM, what each side expects back.
  typedef enum {M_HOST, M_DRAIN, M_GEN, M_REL} mown_e;
  mown_e         m_own;
  int            m_cnt;
  logic [AW-1:0] m_last;
  logic [DW-1:0] ref_mem [1024];
  bit            m_hpend, m_gpend;
  logic [DW-1:0] m_hdat, m_gdat;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_init();
    m_own = M_HOST; m_cnt = 0; m_last = '0;
    m_hpend = 0; m_gpend = 0; m_hdat = '0; m_gdat = '0;
  endtask

  task automatic drive(input bit hr, input bit hw, input int ha, input int hd,
                       input bit gr, input int ga);
    bus.host_req   = hr;
    bus.host_we    = hw;
    bus.host_addr  = AW'(ha);
    bus.host_wdata = DW'(hd);
    bus.gen_req    = gr;
    bus.gen_addr   = AW'(ga);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0);
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    bit            host_ok, gen_ok;
    int            rej;
    logic [AW-1:0] exp_addr;
    @(negedge clk);
    host_ok  = bus.host_req && (m_own == M_HOST);
    gen_ok   = bus.gen_req  && (m_own == M_GEN);
    exp_addr = host_ok ? bus.host_addr : (gen_ok ? bus.gen_addr : m_last);
    chk("host_gnt",    32'(bus.host_gnt),    32'(host_ok));
    chk("host_err",    32'(bus.host_err),    32'(bus.host_req && !host_ok));
    chk("gen_gnt",     32'(bus.gen_gnt),     32'(gen_ok));
    chk("ram_we",      32'(bus.ram_we),      32'(host_ok && bus.host_we));
    chk("ram_addr",    32'(bus.ram_addr),    32'(exp_addr));
    chk("host_rvalid", 32'(bus.host_rvalid), 32'(m_hpend));
    chk("gen_rvalid",  32'(bus.gen_rvalid),  32'(m_gpend));
    chk("gen_owner",   32'(gen_owner),       32'(m_own == M_GEN));
    chk("err_count",   32'(err_count),       32'(m_cnt));
    if (host_ok && bus.host_we) chk("ram_wdata", 32'(bus.ram_wdata), 32'(bus.host_wdata));
    if (m_hpend) chk("host_rdata", 32'(bus.host_rdata), 32'(m_hdat));
    if (m_gpend) chk("gen_rdata",  32'(bus.gen_rdata),  32'(m_gdat));
    @(posedge clk);
    if (reset) begin
      model_init();
    end else begin
      rej = int'(bus.host_req && !host_ok) + int'(bus.gen_req && !gen_ok);
      m_cnt = err_clr ? 0 : ((m_cnt + rej > 255) ? 255 : m_cnt + rej);
      m_hpend = host_ok && !bus.host_we;
      m_hdat  = ref_mem[bus.host_addr];
      m_gpend = gen_ok;
      m_gdat  = ref_mem[bus.gen_addr];
      if (host_ok && bus.host_we) ref_mem[bus.host_addr] = bus.host_wdata;
      m_last = exp_addr;
      case (m_own)
        M_HOST:  if (tx_active) m_own = M_DRAIN;
        M_DRAIN: m_own = tx_active ? M_GEN : M_REL;
        M_GEN:   if (!tx_active) m_own = M_REL;
        default: m_own = M_HOST;
      endcase
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, one checked cycle under reset.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    model_init();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_active = 1'b0; err_clr = 1'b0;
    idle();
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    model_init();
    @(posedge clk); #1;
    cycle();
    reset = 1'b0;

    // Host write then read back
    drive(1, 1, 'h010, 'hA5, 0, 0); cycle();
    drive(1, 0, 'h010, 0, 0, 0);    cycle();
    idle(); cycle();

    // Read in flight while the modulator takes over
    tx_active = 1'b1;
    drive(1, 0, 'h010, 0, 0, 0); cycle();
    idle(); cycle(); cycle();
    chk("t2_owner", 32'(gen_owner), 32'(1));

    // Back-to-back modulator reads
    for (int a = 0; a < 4; a++) begin
      drive(0, 0, 0, 0, 1, a); cycle();
    end
    idle(); cycle();

    // Rejected host write while modulator owns the port
    drive(1, 1, 'h010, 'hFF, 0, 0); cycle();
    idle(); cycle();
    chk("t4_errcnt", 32'(err_count), 32'(1));
    tx_active = 1'b0; cycle(); cycle();
    drive(1, 0, 'h010, 0, 0, 0); cycle();
    idle(); cycle();

    // Saturation and clear-over-increment
    tx_active = 1'b1; cycle(); cycle();
    for (int i = 0; i < 300; i++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 1023), $urandom, 0, 0); cycle();
    end
    chk("t5_sat", 32'(err_count), 32'(255));
    err_clr = 1'b1; drive(1, 0, 0, 0, 0, 0); cycle();
    err_clr = 1'b0; idle(); cycle();

    // One-cycle tx pulse, then reset with a read in flight
    tx_active = 1'b0; cycle(); cycle();
    tx_active = 1'b1; cycle();
    tx_active = 1'b0; cycle(); cycle(); cycle();
    drive(1, 0, 'h002, 0, 0, 0); cycle();
    do_reset();
    idle(); cycle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) tx_active = ~tx_active;
      err_clr = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end
    err_clr = 1'b0; idle(); cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
